// File: rtl/lcd_msg_scheduler.sv
// Fixed-priority scheduler that picks one of four display requests for the LCD.
// Each granted code is held for HOLD_CYCLES; requester 0 may cut a foreign hold short.
module lcd_msg_scheduler #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26,
  parameter logic [7:0]  IDLE_CODE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_code,
  output logic [7:0]  state_out,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        holding,
  output logic [3:0]  pending,
  output logic        overwrite
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         disp_q, disp_d;
  logic [1:0]         owner_q, owner_d;
  logic [3:0]         grant_q, grant_d;
  logic [3:0]         pend_q, pend_d;
  logic [7:0]         code_q [4];
  logic [7:0]         code_d [4];
  logic               ovw_q, ovw_d;

  logic [1:0]         win;
  logic               preempt;
  logic               load;
  logic               hold_done;

  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) win = 2'(i);
    end
  end

  assign preempt   = (state_q == StHold) && pend_q[0] && (owner_q != 2'd0);
  assign load      = ((state_q == StIdle) && (pend_q != 4'd0)) || preempt;
  assign hold_done = (state_q == StHold) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (load) state_d = StHold;
      StHold: if (!preempt && hold_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    owner_d = owner_q;
    grant_d = 4'd0;
    pend_d  = pend_q;
    ovw_d   = 1'b0;
    for (int i = 0; i < 4; i++) code_d[i] = code_q[i];

    if (load) begin
      cnt_d        = '0;
      disp_d       = code_q[win];
      owner_d      = win;
      grant_d[win] = 1'b1;
      pend_d[win]  = 1'b0;
    end else if (hold_done) begin
      cnt_d = '0;
    end else if (state_q == StHold) begin
      cnt_d = cnt_q + 1'b1;
    end

    // A new request always wins over a same-edge grant of its slot.
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (pend_q[i] && !(load && (win == 2'(i)))) ovw_d = 1'b1;
        pend_d[i] = 1'b1;
        code_d[i] = req_code[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      disp_q  <= IDLE_CODE;
      owner_q <= 2'd0;
      grant_q <= 4'd0;
      pend_q  <= 4'd0;
      ovw_q   <= 1'b0;
      for (int i = 0; i < 4; i++) code_q[i] <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      ovw_q   <= ovw_d;
      for (int i = 0; i < 4; i++) code_q[i] <= code_d[i];
    end
  end

  assign state_out = disp_q;
  assign owner     = owner_q;
  assign grant     = grant_q;
  assign pending   = pend_q;
  assign overwrite = ovw_q;
  assign holding   = (state_q == StHold);

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Bench for lcd_msg_scheduler with HOLD_CYCLES=8, checked against a countdown-based
// behavioural model of the display schedule.
module tb_lcd_msg_scheduler;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [31:0] req_code = 32'd0;
  logic [7:0]  state_out;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        holding;
  logic [3:0]  pending;
  logic        overwrite;

  int passed = 0;
  int total  = 0;
  int cyc_n  = 0;

  // Reference model: hold time kept as cycles remaining on screen.
  logic [3:0] m_pend;
  logic [7:0] m_code [4];
  logic [7:0] m_disp;
  logic [1:0] m_owner;
  int         m_hold;
  logic [3:0] m_grant;
  logic       m_ov;

  lcd_msg_scheduler #(
    .HOLD_CYCLES(H),
    .CNT_W(4),
    .IDLE_CODE(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_code(req_code),
    .state_out(state_out),
    .grant(grant),
    .owner(owner),
    .holding(holding),
    .pending(pending),
    .overwrite(overwrite)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] expv();
    return {m_disp, m_grant, m_owner, (m_hold > 0), m_pend, m_ov};
  endfunction

  function automatic logic [19:0] dutv();
    return {state_out, grant, owner, holding, pending, overwrite};
  endfunction

  task automatic model_reset();
    m_pend = 4'd0; m_disp = 8'h00; m_owner = 2'd0; m_hold = 0; m_grant = 4'd0; m_ov = 1'b0;
    for (int i = 0; i < 4; i++) m_code[i] = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] c);
    logic [3:0] old;
    int w;
    old = m_pend;
    w = -1;
    if ((m_hold == 0 && m_pend != 0) || (m_hold > 0 && m_pend[0] && m_owner != 2'd0))
      for (int i = 3; i >= 0; i--) if (m_pend[i]) w = i;
    m_grant = 4'd0;
    m_ov = 1'b0;
    if (w >= 0) begin
      m_disp = m_code[w]; m_owner = 2'(w); m_grant[w] = 1'b1; m_pend[w] = 1'b0; m_hold = H;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        if (old[i] && w != i) m_ov = 1'b1;
        m_pend[i] = 1'b1;
        m_code[i] = c[8*i +: 8];
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [31:0] c);
    req = r;
    req_code = c;
    @(posedge clk);
    model_step(r, c);
    #1;
    req = 4'd0;
    cyc_n++;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (m_hold == 0 && m_pend == 0) break;
      cyc(4'd0, 32'd0);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(4'd0, 32'd0);
      total++;
      if (dutv() !== expv()) $display("FAIL reset_idle cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
    end
    total++;
    if ({state_out, grant, pending, holding} !== 17'd0)
      $display("FAIL reset_vals: got %h/%b/%b/%b exp 00/0000/0000/0", state_out, grant, pending, holding);
    else passed++;
  endtask

  task automatic test_single();
    int hcount;
    cyc(4'b0100, 32'h0010_0000);
    total++;
    if (pending !== 4'b0100 || state_out !== 8'h00)
      $display("FAIL single_pend: got pend %b state %h exp 0100 00", pending, state_out);
    else passed++;
    cyc(4'd0, 32'd0);
    total++;
    if (state_out !== 8'h10 || grant !== 4'b0100 || owner !== 2'd2)
      $display("FAIL single_grant: got %h %b %0d exp 10 0100 2", state_out, grant, owner);
    else passed++;
    hcount = holding ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'd0, 32'd0);
      total++;
      if (dutv() !== expv()) $display("FAIL single cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
      if (!holding) break;
      hcount++;
    end
    total++;
    if (hcount != H || pending !== 4'd0)
      $display("FAIL single_hold: got %0d cycles pend %b exp %0d 0000", hcount, pending, H);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int g1, g2;
    logic [11:0] s1, s2;
    g1 = -1; g2 = -1; s1 = 12'd0; s2 = 12'd0;
    cyc(4'b1010, 32'h1200_0100);
    for (int i = 0; i < 30; i++) begin
      cyc(4'd0, 32'd0);
      total++;
      if (dutv() !== expv()) $display("FAIL simul cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
      if (grant != 4'd0) begin
        if (g1 < 0) begin g1 = cyc_n; s1 = {state_out, grant}; end
        else if (g2 < 0) begin g2 = cyc_n; s2 = {state_out, grant}; end
      end
    end
    total++;
    if (s1 !== 12'h012 || s2 !== 12'h128 || g1 < 0 || g2 - g1 != H + 1)
      $display("FAIL simul_order: got %h %h gap %0d exp 012 128 gap %0d", s1, s2, g2 - g1, H + 1);
    else passed++;
  endtask

  task automatic test_preempt();
    int t0, t1;
    t1 = -1;
    drain();
    cyc(4'b1000, 32'h2000_0000);
    cyc(4'd0, 32'd0);
    repeat (3) cyc(4'd0, 32'd0);
    cyc(4'b0001, 32'h0000_0030);
    cyc(4'd0, 32'd0);
    total++;
    if (state_out !== 8'h30 || owner !== 2'd0 || grant !== 4'b0001 || !holding)
      $display("FAIL preempt: got %h %0d %b %b exp 30 0 0001 1", state_out, owner, grant, holding);
    else passed++;
    t0 = cyc_n;
    cyc(4'b0001, 32'h0000_0031);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (dutv() !== expv()) $display("FAIL preempt cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
      if (grant == 4'b0001 && state_out == 8'h31) begin t1 = cyc_n; break; end
      cyc(4'd0, 32'd0);
    end
    total++;
    if (t1 - t0 != H + 1) $display("FAIL self_nopreempt: got gap %0d exp %0d", t1 - t0, H + 1);
    else passed++;
  endtask

  task automatic test_overwrite();
    int ovc;
    logic [7:0] shown;
    shown = 8'hxx;
    drain();
    cyc(4'b1000, 32'h2100_0000);
    cyc(4'd0, 32'd0);
    cyc(4'b0100, 32'h0011_0000);
    ovc = overwrite ? 1 : 0;
    cyc(4'b0100, 32'h0013_0000);
    total++;
    if (overwrite !== 1'b1) $display("FAIL overwrite_pulse: got %b exp 1", overwrite);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      if (overwrite) ovc++;
      if (grant == 4'b0100) begin shown = state_out; break; end
      cyc(4'd0, 32'd0);
      total++;
      if (dutv() !== expv()) $display("FAIL ovw cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
    end
    total++;
    if (shown !== 8'h13 || ovc != 1)
      $display("FAIL overwrite_code: got %h pulses %0d exp 13 1", shown, ovc);
    else passed++;
  endtask

  task automatic test_async_reset();
    drain();
    cyc(4'b0010, 32'h0000_5500);
    cyc(4'd0, 32'd0);
    cyc(4'b0001, 32'h0000_0077);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    total++;
    if (dutv() !== 20'd0) $display("FAIL async_reset: got %h exp 00000", dutv());
    else passed++;
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(4'd0, 32'd0);
      total++;
      if (dutv() !== expv() || state_out !== 8'h00)
        $display("FAIL post_reset cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    drain();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      cyc(r, $urandom);
      total++;
      if (dutv() !== expv()) $display("FAIL random cyc %0d: got %h exp %h", cyc_n, dutv(), expv());
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_overwrite();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
